// File: rtl/lii_mem_target_bridge_pkg.sv
// Shared definitions for the LII memory link: opcodes, AXI response codes,
// header layout and the header pack/unpack helpers used by both link ends.
package lii_mem_target_bridge_pkg;

  localparam int HDR_AW = 48;
  localparam int OP_W   = 2;
  localparam int LEN_W  = 8;
  localparam int SIZE_W = 3;
  localparam int TAG_W  = 8;
  localparam int HDR_W  = OP_W + LEN_W + SIZE_W + HDR_AW + TAG_W;

  // Field offsets measured down from the flit MSB
  localparam int OP_OFS   = 0;
  localparam int LEN_OFS  = OP_OFS + OP_W;
  localparam int SIZE_OFS = LEN_OFS + LEN_W;
  localparam int ADDR_OFS = SIZE_OFS + SIZE_W;
  localparam int TAG_OFS  = ADDR_OFS + HDR_AW;

  localparam logic [1:0] OP_READ     = 2'b00;
  localparam logic [1:0] OP_WRITE    = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_RD,
    S_AW,
    S_WD,
    S_B,
    S_ACK
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [LEN_W-1:0]  len;
    logic [SIZE_W-1:0] size;
    logic [HDR_AW-1:0] addr;
    logic [TAG_W-1:0]  tag;
  } hdr_t;

  function automatic hdr_t unpack_hdr(input logic [HDR_W-1:0] top_bits);
    return hdr_t'(top_bits);
  endfunction

  function automatic logic [HDR_W-1:0] pack_hdr(input hdr_t h);
    return h;
  endfunction

endpackage

// File: rtl/lii_mem_target_bridge_if.sv
// LII request/response flit channels plus the memory-side AXI4 master bus.
// master = bridge view, slave = fabric/memory view.
interface lii_mem_target_bridge_if #(
  parameter int AXI_AW = 48,
  parameter int AXI_DW = 256,
  parameter int LII_DW = 512
);
  logic [LII_DW-1:0]   lii_req_tdata;
  logic [LII_DW/8-1:0] lii_req_tkeep;
  logic [LII_DW/8-1:0] lii_req_tstrb;
  logic                lii_req_tlast;
  logic [7:0]          lii_req_src;
  logic [7:0]          lii_req_dst;
  logic                lii_req_tvalid;
  logic                lii_req_tready;

  logic [LII_DW-1:0]   lii_resp_tdata;
  logic [LII_DW/8-1:0] lii_resp_tkeep;
  logic [LII_DW/8-1:0] lii_resp_tstrb;
  logic                lii_resp_tlast;
  logic [7:0]          lii_resp_src;
  logic [7:0]          lii_resp_dst;
  logic                lii_resp_tvalid;
  logic                lii_resp_tready;

  logic [AXI_AW-1:0]   aximm_araddr;
  logic [7:0]          aximm_arlen;
  logic [2:0]          aximm_arsize;
  logic [1:0]          aximm_arburst;
  logic                aximm_arvalid;
  logic                aximm_arready;
  logic [AXI_DW-1:0]   aximm_rdata;
  logic [1:0]          aximm_rresp;
  logic                aximm_rlast;
  logic                aximm_rvalid;
  logic                aximm_rready;

  logic [AXI_AW-1:0]   aximm_awaddr;
  logic [7:0]          aximm_awlen;
  logic [2:0]          aximm_awsize;
  logic [1:0]          aximm_awburst;
  logic                aximm_awvalid;
  logic                aximm_awready;
  logic [AXI_DW-1:0]   aximm_wdata;
  logic [AXI_DW/8-1:0] aximm_wstrb;
  logic                aximm_wlast;
  logic                aximm_wvalid;
  logic                aximm_wready;
  logic [1:0]          aximm_bresp;
  logic                aximm_bvalid;
  logic                aximm_bready;

  logic                err_len_mismatch;

  modport master (
    input  lii_req_tdata, lii_req_tkeep, lii_req_tstrb, lii_req_tlast,
           lii_req_src, lii_req_dst, lii_req_tvalid,
    output lii_req_tready,
    output lii_resp_tdata, lii_resp_tkeep, lii_resp_tstrb, lii_resp_tlast,
           lii_resp_src, lii_resp_dst, lii_resp_tvalid,
    input  lii_resp_tready,
    output aximm_araddr, aximm_arlen, aximm_arsize, aximm_arburst, aximm_arvalid,
    input  aximm_arready,
    input  aximm_rdata, aximm_rresp, aximm_rlast, aximm_rvalid,
    output aximm_rready,
    output aximm_awaddr, aximm_awlen, aximm_awsize, aximm_awburst, aximm_awvalid,
    input  aximm_awready,
    output aximm_wdata, aximm_wstrb, aximm_wlast, aximm_wvalid,
    input  aximm_wready,
    input  aximm_bresp, aximm_bvalid,
    output aximm_bready,
    output err_len_mismatch
  );

  modport slave (
    output lii_req_tdata, lii_req_tkeep, lii_req_tstrb, lii_req_tlast,
           lii_req_src, lii_req_dst, lii_req_tvalid,
    input  lii_req_tready,
    input  lii_resp_tdata, lii_resp_tkeep, lii_resp_tstrb, lii_resp_tlast,
           lii_resp_src, lii_resp_dst, lii_resp_tvalid,
    output lii_resp_tready,
    input  aximm_araddr, aximm_arlen, aximm_arsize, aximm_arburst, aximm_arvalid,
    output aximm_arready,
    output aximm_rdata, aximm_rresp, aximm_rlast, aximm_rvalid,
    input  aximm_rready,
    input  aximm_awaddr, aximm_awlen, aximm_awsize, aximm_awburst, aximm_awvalid,
    output aximm_awready,
    input  aximm_wdata, aximm_wstrb, aximm_wlast, aximm_wvalid,
    output aximm_wready,
    output aximm_bresp, aximm_bvalid,
    input  aximm_bready,
    input  err_len_mismatch
  );
endinterface

// File: rtl/lii_mem_target_bridge.sv
// Target end of the LII memory link: decodes one request header at a time,
// replays it as an AXI4 burst and returns read data flits or a write ack flit.
module lii_mem_target_bridge
  import lii_mem_target_bridge_pkg::*;
#(
  parameter int AXI_AW = HDR_AW,
  parameter int AXI_DW = 256,
  parameter int LII_DW = 512
) (
  input logic clk,
  input logic rstn,
  lii_mem_target_bridge_if.master bus
);

  localparam int SW = AXI_DW / 8;

  state_t     state_q, state_d;
  hdr_t       hdr_q, hdr_d, hdr_in;
  logic [7:0] src_q, src_d, dst_q, dst_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic [1:0] bresp_q, bresp_d;
  logic       err_q, err_d;
  logic       run_q;
  logic       wlast;
  logic       in_rd, in_ack;
  logic       unused_bits;

  assign hdr_in = unpack_hdr(bus.lii_req_tdata[LII_DW-1 -: HDR_W]);
  assign wlast  = (beat_cnt_q == hdr_q.len);
  assign in_rd  = (state_q == S_RD);
  assign in_ack = (state_q == S_ACK);

  assign bus.aximm_araddr  = AXI_AW'(hdr_q.addr);
  assign bus.aximm_arlen   = hdr_q.len;
  assign bus.aximm_arsize  = hdr_q.size;
  assign bus.aximm_arburst = BURST_INCR;
  assign bus.aximm_arvalid = (state_q == S_AR);
  assign bus.aximm_rready  = in_rd & bus.lii_resp_tready;

  assign bus.aximm_awaddr  = AXI_AW'(hdr_q.addr);
  assign bus.aximm_awlen   = hdr_q.len;
  assign bus.aximm_awsize  = hdr_q.size;
  assign bus.aximm_awburst = BURST_INCR;
  assign bus.aximm_awvalid = (state_q == S_AW);

  // Write data streams straight from request flits; only wlast is ours
  assign bus.aximm_wdata  = bus.lii_req_tdata[AXI_DW-1:0];
  assign bus.aximm_wstrb  = bus.lii_req_tstrb[SW-1:0];
  assign bus.aximm_wlast  = wlast;
  assign bus.aximm_wvalid = (state_q == S_WD) & bus.lii_req_tvalid;
  assign bus.aximm_bready = (state_q == S_B);

  assign bus.lii_req_tready = (state_q == S_IDLE) ? run_q :
                              (state_q == S_WD)   ? bus.aximm_wready : 1'b0;

  assign bus.lii_resp_tvalid = (in_rd & bus.aximm_rvalid) | in_ack;
  assign bus.lii_resp_tdata  = in_rd
      ? {{(LII_DW-AXI_DW-2){1'b0}}, bus.aximm_rresp, bus.aximm_rdata}
      : {{(LII_DW-2){1'b0}}, bresp_q};
  assign bus.lii_resp_tkeep  = in_rd ? '1 : '0;
  assign bus.lii_resp_tstrb  = '0;
  assign bus.lii_resp_tlast  = in_rd ? bus.aximm_rlast : in_ack;
  assign bus.lii_resp_src    = dst_q;
  assign bus.lii_resp_dst    = src_q;

  assign bus.err_len_mismatch = err_q;

  assign unused_bits = ^{bus.lii_req_tkeep, bus.lii_req_tdata, bus.lii_req_tstrb, hdr_q.tag};

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    src_d      = src_q;
    dst_d      = dst_q;
    beat_cnt_d = beat_cnt_q;
    bresp_d    = bresp_q;
    err_d      = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (run_q && bus.lii_req_tvalid) begin
          hdr_d      = hdr_in;
          src_d      = bus.lii_req_src;
          dst_d      = bus.lii_req_dst;
          beat_cnt_d = 8'd0;
          unique case (hdr_in.op)
            OP_READ:  state_d = S_AR;
            OP_WRITE: state_d = S_AW;
            default: begin
              bresp_d = RESP_SLVERR;
              state_d = S_ACK;
            end
          endcase
        end
      end
      S_AR: if (bus.aximm_arready) state_d = S_RD;
      S_RD: begin
        if (bus.aximm_rvalid && bus.lii_resp_tready && bus.aximm_rlast) state_d = S_IDLE;
      end
      S_AW: begin
        if (bus.aximm_awready) begin
          beat_cnt_d = 8'd0;
          state_d    = S_WD;
        end
      end
      S_WD: begin
        // The header length is authoritative; a disagreeing tlast only flags
        if (bus.lii_req_tvalid && bus.aximm_wready) begin
          if (bus.lii_req_tlast != wlast) err_d = 1'b1;
          if (wlast) state_d = S_B;
          else       beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      S_B: begin
        if (bus.aximm_bvalid) begin
          bresp_d = bus.aximm_bresp;
          state_d = S_ACK;
        end
      end
      S_ACK: if (bus.lii_resp_tready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      hdr_q      <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      beat_cnt_q <= '0;
      bresp_q    <= '0;
      err_q      <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      beat_cnt_q <= beat_cnt_d;
      bresp_q    <= bresp_d;
      err_q      <= err_d;
      run_q      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lii_mem_target_bridge.sv
// Bench for lii_mem_target_bridge: directed transactions against an AXI memory
// model, with expected-flit/beat queues checked every cycle by one monitor.
module tb_lii_mem_target_bridge;
  import lii_mem_target_bridge_pkg::*;

  localparam int AW = 48;
  localparam int DW = 256;
  localparam int LW = 512;
  localparam int KW = LW / 8;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  lii_mem_target_bridge_if #(.AXI_AW(AW), .AXI_DW(DW), .LII_DW(LW)) bus ();

  lii_mem_target_bridge #(.AXI_AW(AW), .AXI_DW(DW), .LII_DW(LW)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  typedef struct packed {
    logic [LW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [7:0]    src;
    logic [7:0]    dst;
  } rsp_t;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
  } a_t;
  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
  } w_t;

  rsp_t exp_resp[$];
  a_t   exp_ar[$];
  a_t   exp_aw[$];
  w_t   exp_w[$];

  int n_checks = 0;
  int n_fail   = 0;
  int rt_mode  = 0;
  bit mem_bp   = 1'b0;
  logic [1:0] bresp_cfg = 2'b00;
  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, rsp_cnt = 0;
  rsp_t last_rsp;
  w_t   last_w;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a, input int i);
    return {4{a[31:0] + 32'(i), 32'hC0DE_0000 | 32'(i)}};
  endfunction

  function automatic logic [LW-1:0] mk_hdr(input logic [1:0] op, input logic [7:0] len,
                                           input logic [2:0] size, input logic [AW-1:0] addr,
                                           input logic [7:0] tag);
    logic [LW-1:0] f;
    f = '0;
    f[LW-1 -: (2+8+3+AW+8)] = {op, len, size, addr, tag};
    return f;
  endfunction

  function automatic logic [LW-1:0] rnd_flit();
    logic [LW-1:0] f;
    for (int k = 0; k < LW/32; k++) f[k*32 +: 32] = $urandom;
    return f;
  endfunction

  // AXI memory model: accepts bursts, returns mem_word data, acks writes
  logic [AW-1:0] m_a, rd_addr;
  logic [7:0]    m_l;
  int            rd_len, rd_idx;
  bit            rd_act, b_pend, ar_hs, r_hs, wl_hs, b_hs, r_hold;

  initial begin
    bus.aximm_arready = 1'b0; bus.aximm_awready = 1'b0; bus.aximm_wready = 1'b0;
    bus.aximm_rvalid = 1'b0; bus.aximm_rdata = '0; bus.aximm_rresp = 2'b00; bus.aximm_rlast = 1'b0;
    bus.aximm_bvalid = 1'b0; bus.aximm_bresp = 2'b00;
    rd_act = 0; b_pend = 0; rd_idx = 0; rd_len = 0; rd_addr = '0;
    forever begin
      @(negedge clk);
      ar_hs = bus.aximm_arvalid & bus.aximm_arready;
      m_a   = bus.aximm_araddr;
      m_l   = bus.aximm_arlen;
      r_hs  = bus.aximm_rvalid & bus.aximm_rready;
      wl_hs = bus.aximm_wvalid & bus.aximm_wready & bus.aximm_wlast;
      b_hs  = bus.aximm_bvalid & bus.aximm_bready;
      @(posedge clk); #1;
      if (!rstn) begin
        rd_act = 0; b_pend = 0;
        bus.aximm_rvalid = 1'b0; bus.aximm_bvalid = 1'b0;
        bus.aximm_arready = 1'b0; bus.aximm_awready = 1'b0; bus.aximm_wready = 1'b0;
        continue;
      end
      r_hold = bus.aximm_rvalid && !r_hs;
      if (r_hs) begin
        if (rd_idx == rd_len) rd_act = 0;
        else rd_idx++;
      end
      if (ar_hs) begin
        rd_act = 1; rd_addr = m_a; rd_len = int'(m_l); rd_idx = 0;
      end
      if (b_hs)  b_pend = 0;
      if (wl_hs) b_pend = 1;
      if (!rd_act) bus.aximm_rvalid = 1'b0;
      else if (!r_hold) bus.aximm_rvalid = mem_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.aximm_rdata   = mem_word(rd_addr, rd_idx);
      bus.aximm_rlast   = (rd_idx == rd_len);
      bus.aximm_rresp   = 2'b00;
      bus.aximm_bvalid  = b_pend;
      bus.aximm_bresp   = bresp_cfg;
      bus.aximm_arready = mem_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.aximm_awready = mem_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.aximm_wready  = mem_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    bus.lii_resp_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.lii_resp_tready = (rt_mode == 0) ? 1'b1 :
                            (rt_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Compare process: every handshake against the expectation queues, plus hold rules
  bit   ps_ar, ps_aw, ps_w, ps_rsp;
  a_t   pa_ar, pa_aw, cur_ar, cur_aw, e_a;
  w_t   pw, cur_w, e_w;
  rsp_t pr, cur_r, e_r;

  initial begin
    ps_ar = 0; ps_aw = 0; ps_w = 0; ps_rsp = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        ps_ar = 0; ps_aw = 0; ps_w = 0; ps_rsp = 0;
        continue;
      end
      cur_ar = '{bus.aximm_araddr, bus.aximm_arlen, bus.aximm_arsize};
      cur_aw = '{bus.aximm_awaddr, bus.aximm_awlen, bus.aximm_awsize};
      cur_w  = '{bus.aximm_wdata, bus.aximm_wstrb, bus.aximm_wlast};
      cur_r  = '{bus.lii_resp_tdata, bus.lii_resp_tkeep, bus.lii_resp_tlast,
                 bus.lii_resp_src, bus.lii_resp_dst};
      if (ps_ar) begin chk("ar_hold_valid", bus.aximm_arvalid, 1'b1); chk("ar_hold", cur_ar, pa_ar); end
      if (ps_aw) begin chk("aw_hold_valid", bus.aximm_awvalid, 1'b1); chk("aw_hold", cur_aw, pa_aw); end
      if (ps_w)  begin chk("w_hold_valid", bus.aximm_wvalid, 1'b1);   chk("w_hold", cur_w, pw); end
      if (ps_rsp) begin chk("resp_hold_valid", bus.lii_resp_tvalid, 1'b1); chk("resp_hold", cur_r, pr); end

      if (bus.aximm_arvalid && bus.aximm_arready) begin
        ar_cnt++;
        if (exp_ar.size() == 0) chk("ar_unexpected", 1'b1, 1'b0);
        else begin
          e_a = exp_ar.pop_front();
          chk("ar_fields", cur_ar, e_a);
          chk("ar_burst", bus.aximm_arburst, 2'b01);
        end
      end
      if (bus.aximm_awvalid && bus.aximm_awready) begin
        aw_cnt++;
        if (exp_aw.size() == 0) chk("aw_unexpected", 1'b1, 1'b0);
        else begin
          e_a = exp_aw.pop_front();
          chk("aw_fields", cur_aw, e_a);
          chk("aw_burst", bus.aximm_awburst, 2'b01);
        end
      end
      if (bus.aximm_wvalid && bus.aximm_wready) begin
        w_cnt++;
        last_w = cur_w;
        if (exp_w.size() == 0) chk("w_unexpected", 1'b1, 1'b0);
        else begin
          e_w = exp_w.pop_front();
          chk("w_data", cur_w.data, e_w.data);
          chk("w_strb", cur_w.strb, e_w.strb);
          chk("w_last", cur_w.last, e_w.last);
        end
      end
      if (bus.lii_resp_tvalid && bus.lii_resp_tready) begin
        rsp_cnt++;
        last_rsp = cur_r;
        chk("resp_tstrb", bus.lii_resp_tstrb, '0);
        if (exp_resp.size() == 0) chk("resp_unexpected", 1'b1, 1'b0);
        else begin
          e_r = exp_resp.pop_front();
          chk("resp_data", cur_r.data, e_r.data);
          chk("resp_keep", cur_r.keep, e_r.keep);
          chk("resp_last", cur_r.last, e_r.last);
          chk("resp_route", {cur_r.src, cur_r.dst}, {e_r.src, e_r.dst});
        end
      end
      ps_ar = bus.aximm_arvalid & !bus.aximm_arready;     pa_ar = cur_ar;
      ps_aw = bus.aximm_awvalid & !bus.aximm_awready;     pa_aw = cur_aw;
      ps_w  = bus.aximm_wvalid & !bus.aximm_wready;       pw    = cur_w;
      ps_rsp = bus.lii_resp_tvalid & !bus.lii_resp_tready; pr   = cur_r;
    end
  end

  task automatic send_flit(input logic [LW-1:0] d, input logic [KW-1:0] s, input logic l,
                           input logic [7:0] src, input logic [7:0] dst);
    bit hs;
    int n;
    bus.lii_req_tdata = d; bus.lii_req_tkeep = '1; bus.lii_req_tstrb = s;
    bus.lii_req_tlast = l; bus.lii_req_src = src; bus.lii_req_dst = dst;
    bus.lii_req_tvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      hs = bus.lii_req_tready;
      @(posedge clk); #1;
      n++;
    end while (!hs && n < 3000);
    if (!hs) chk("req_accept_timeout", 1'b0, 1'b1);
    bus.lii_req_tvalid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_resp.size() + exp_ar.size() + exp_aw.size() + exp_w.size()) != 0 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    if ((exp_resp.size() + exp_ar.size() + exp_aw.size() + exp_w.size()) != 0) begin
      chk("done_timeout", 1'b0, 1'b1);
      exp_resp.delete(); exp_ar.delete(); exp_aw.delete(); exp_w.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic push_read(input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [7:0] src, input logic [7:0] dst);
    exp_ar.push_back('{addr, len, 3'd5});
    for (int i = 0; i <= int'(len); i++)
      exp_resp.push_back('{LW'(mem_word(addr, i)), {KW{1'b1}}, (i == int'(len)), dst, src});
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [7:0] src, input logic [7:0] dst);
    push_read(addr, len, src, dst);
    send_flit(mk_hdr(2'b00, len, 3'd5, addr, 8'hA1), '0, 1'b1, src, dst);
    wait_done();
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [KW-1:0] strb, input int tl_at,
                          input logic [7:0] src, input logic [7:0] dst);
    logic [LW-1:0] d;
    exp_aw.push_back('{addr, len, 3'd5});
    exp_resp.push_back('{LW'(bresp_cfg), {KW{1'b0}}, 1'b1, dst, src});
    send_flit(mk_hdr(2'b01, len, 3'd5, addr, 8'h5A), '0, 1'b0, src, dst);
    for (int i = 0; i <= int'(len); i++) begin
      d = rnd_flit();
      exp_w.push_back('{d[DW-1:0], strb[SW-1:0], (i == int'(len))});
      send_flit(d, strb, (i == tl_at), src, dst);
    end
    wait_done();
  endtask

  int c0, c1, c2;

  initial begin : main
    rstn = 1'b0;
    bus.lii_req_tvalid = 1'b0; bus.lii_req_tdata = '0; bus.lii_req_tkeep = '0;
    bus.lii_req_tstrb = '0; bus.lii_req_tlast = 1'b0; bus.lii_req_src = '0; bus.lii_req_dst = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_req_tready", bus.lii_req_tready, 1'b0);
    chk("rst_resp_tvalid", bus.lii_resp_tvalid, 1'b0);
    chk("rst_valids", {bus.aximm_arvalid, bus.aximm_awvalid, bus.aximm_wvalid}, 3'b000);
    chk("rst_readies", {bus.aximm_rready, bus.aximm_bready}, 2'b00);
    chk("rst_err", bus.err_len_mismatch, 1'b0);
    rstn = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("idle_tready", bus.lii_req_tready, 1'b1);

    c0 = rsp_cnt;
    do_read(48'h1000, 8'd3, 8'h11, 8'h22);
    chk("rd4_beats", rsp_cnt - c0, 4);
    chk("rd4_last_data", last_rsp.data[63:0], 64'h0000_1003_C0DE_0003);
    chk("rd4_last_rresp", last_rsp.data[257:256], 2'b00);
    chk("rd4_last_flags", {last_rsp.last, last_rsp.src, last_rsp.dst}, {1'b1, 8'h22, 8'h11});
    chk("rd4_keep", last_rsp.keep, {KW{1'b1}});

    c0 = w_cnt;
    do_write(48'h2000, 8'd1, 64'hFFFF_0000, 1, 8'h33, 8'h44);
    chk("wr2_beats", w_cnt - c0, 2);
    chk("wr2_strb", last_w.strb, 32'hFFFF_0000);
    chk("wr2_wlast", last_w.last, 1'b1);
    chk("wr2_ack", {last_rsp.data, last_rsp.keep, last_rsp.last}, {{LW{1'b0}}, {KW{1'b0}}, 1'b1});
    chk("wr2_err", bus.err_len_mismatch, 1'b0);

    bresp_cfg = 2'b10;
    do_write(48'h3000, 8'd0, {KW{1'b1}}, 0, 8'h01, 8'h02);
    chk("wr_slverr_ack", last_rsp.data[1:0], 2'b10);
    bresp_cfg = 2'b00;

    c0 = ar_cnt; c1 = aw_cnt;
    exp_resp.push_back('{LW'(2'b10), {KW{1'b0}}, 1'b1, 8'h66, 8'h55});
    send_flit(mk_hdr(2'b11, 8'd4, 3'd5, 48'h4000, 8'h00), '0, 1'b1, 8'h55, 8'h66);
    wait_done();
    chk("badop_no_axi", {32'(ar_cnt - c0), 32'(aw_cnt - c1)}, 64'd0);
    chk("badop_ack", last_rsp.data[1:0], 2'b10);

    mem_bp = 1'b1; rt_mode = 1;
    do_read(48'h0001_0000_0100, 8'd7, 8'h0A, 8'h0B);
    do_write(48'h5000, 8'd5, 64'h0F0F_F0F0_1234_5678, 5, 8'h0C, 8'h0D);
    c0 = rsp_cnt;
    do_read(48'h8000, 8'd255, 8'h0E, 8'h0F);
    chk("rd256_beats", rsp_cnt - c0, 256);
    chk("rd256_last_data", last_rsp.data[63:0], 64'h0000_80FF_C0DE_00FF);
    mem_bp = 1'b0; rt_mode = 0;
    @(posedge clk); #1;

    c0 = w_cnt;
    do_write(48'h6000, 8'd2, {KW{1'b1}}, 1, 8'h21, 8'h12);
    chk("mis_beats", w_cnt - c0, 3);
    chk("mis_wlast", last_w.last, 1'b1);
    chk("mis_err", bus.err_len_mismatch, 1'b1);
    do_write(48'h6100, 8'd0, {KW{1'b1}}, 0, 8'h21, 8'h12);
    chk("mis_err_sticky", bus.err_len_mismatch, 1'b1);

    rt_mode = 2;
    @(posedge clk); #1;
    push_read(48'h7000, 8'd7, 8'h31, 8'h13);
    send_flit(mk_hdr(2'b00, 8'd7, 3'd5, 48'h7000, 8'h77), '0, 1'b1, 8'h31, 8'h13);
    c2 = 0;
    while (!bus.lii_resp_tvalid && c2 < 100) begin @(negedge clk); c2++; end
    chk("midrst_stalled_valid", bus.lii_resp_tvalid, 1'b1);
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    chk("midrst_resp_tvalid", bus.lii_resp_tvalid, 1'b0);
    chk("midrst_valids", {bus.aximm_arvalid, bus.aximm_awvalid, bus.aximm_wvalid,
                          bus.aximm_rready, bus.aximm_bready, bus.lii_req_tready}, 6'd0);
    chk("midrst_err_clear", bus.err_len_mismatch, 1'b0);
    exp_resp.delete(); exp_ar.delete(); exp_aw.delete(); exp_w.delete();
    rt_mode = 0;
    repeat (3) @(posedge clk); #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk); #1;
    c0 = rsp_cnt;
    do_read(48'h40, 8'd0, 8'h41, 8'h14);
    chk("post_rst_beats", rsp_cnt - c0, 1);
    chk("post_rst_data", last_rsp.data[63:0], 64'h0000_0040_C0DE_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    n_checks++;
    n_fail++;
    $display("FAIL global_timeout: got running expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
